// File: rtl/core_boot_controller.sv
// rtl/core_boot_controller.sv - program-load / core-reset / supervised-run sequencer for a single-cycle RISC-V core
//
// Purpose:
//   Streams a program into the fetch unit's instruction memory, holds the core
//   in reset for ARM_CYCLES cycles, then runs it while watching for EBREAK, the
//   self-loop `jal x0,0`, or a cycle-count timeout, and freezes the core on halt.
//
// Optional feature (macro CORE_BOOT_ZERO_FILL_EN):
//   When defined, a load that ends with load_last before the memory is full is
//   followed by a FILL phase that writes zero to every remaining address.
//   When undefined, memory beyond the program keeps its prior contents.
//
// Ports:
//   clk, reset         clock; synchronous active-low reset
//   load_valid/ready   program word handshake; load_data word, load_last marks the final word
//   start              one-cycle pulse: run or re-run the loaded program
//   imem_we/waddr/wdata instruction memory write port
//   core_reset         active-high reset to the core
//   pc_in, instr_in    core PC and fetched instruction, observed during RUN
//   busy, halted       status: busy = not IDLE/HALT, halted = HALT
//   halt_cause         00 none, 01 EBREAK, 10 self-loop, 11 timeout
//   halt_pc            pc_in captured at halt detection
//   cycle_count        RUN-phase cycle counter
//   words_loaded       words written by the last load

module core_boot_controller #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_CYCLES = 1024,
  parameter int ARM_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  input  logic [31:0]           pc_in,
  input  logic [31:0]           instr_in,
  output logic                  busy,
  output logic                  halted,
  output logic [1:0]            halt_cause,
  output logic [31:0]           halt_pc,
  output logic [31:0]           cycle_count,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX     = {ADDR_WIDTH{1'b1}};
  localparam logic [31:0]           INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0]           INSTR_SELF   = 32'h0000_006f;
  localparam logic [31:0]           MAX_C        = 32'(MAX_CYCLES);
  localparam logic [31:0]           ARM_C        = 32'(ARM_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARM  = 3'd2,
    S_RUN  = 3'd3,
    S_HALT = 3'd4
`ifdef CORE_BOOT_ZERO_FILL_EN
    , S_FILL = 3'd5
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [31:0]           arm_q, arm_d;
  logic [31:0]           cycle_q, cycle_d;
  logic [1:0]            cause_q, cause_d;
  logic [31:0]           hpc_q, hpc_d;
  logic                  core_reset_q, busy_q, halted_q;
  logic [31:0]           cycle_inc;
  logic                  fill_active;

  assign cycle_inc = cycle_q + 32'd1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    words_d     = words_q;
    arm_d       = arm_q;
    cycle_d     = cycle_q;
    cause_d     = cause_q;
    hpc_d       = hpc_q;
    fill_active = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        // A load request always wins over start; the word itself is taken
        // from the next cycle onward, once load_ready is up.
        if (load_valid) begin
          state_d = S_LOAD;
          addr_d  = '0;
          words_d = '0;
        end else if (start && (state_q == S_HALT || words_q != '0)) begin
          state_d = S_ARM;
          arm_d   = '0;
          cycle_d = '0;
          cause_d = 2'b00;
        end
      end

      S_LOAD: begin
        if (load_valid) begin
          words_d = words_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          // Reaching the last address ends the load regardless of load_last,
          // so nothing past the top of memory is ever written.
          if (addr_q == ADDR_MAX) begin
            state_d = S_IDLE;
          end else if (load_last) begin
`ifdef CORE_BOOT_ZERO_FILL_EN
            state_d = S_FILL;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end

`ifdef CORE_BOOT_ZERO_FILL_EN
      S_FILL: begin
        fill_active = 1'b1;
        if (addr_q == ADDR_MAX) begin
          state_d = S_IDLE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
`endif

      S_ARM: begin
        if (arm_q + 32'd1 >= ARM_C) begin
          state_d = S_RUN;
        end else begin
          arm_d = arm_q + 32'd1;
        end
      end

      S_RUN: begin
        // The count already includes the current cycle, so a timeout halts
        // with cycle_count exactly equal to MAX_CYCLES.
        cycle_d = cycle_inc;
        if (instr_in == INSTR_EBREAK) begin
          cause_d = 2'b01;
        end else if (instr_in == INSTR_SELF) begin
          cause_d = 2'b10;
        end else if (MAX_CYCLES != 0 && cycle_inc == MAX_C) begin
          cause_d = 2'b11;
        end
        if (instr_in == INSTR_EBREAK || instr_in == INSTR_SELF ||
            (MAX_CYCLES != 0 && cycle_inc == MAX_C)) begin
          hpc_d   = pc_in;
          state_d = S_HALT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      words_q      <= '0;
      arm_q        <= '0;
      cycle_q      <= '0;
      cause_q      <= 2'b00;
      hpc_q        <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_q      <= words_d;
      arm_q        <= arm_d;
      cycle_q      <= cycle_d;
      cause_q      <= cause_d;
      hpc_q        <= hpc_d;
      // Status outputs are registered from the next state so they line up
      // with state_q without a decode stage on the output.
      core_reset_q <= (state_d != S_RUN);
      busy_q       <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q     <= (state_d == S_HALT);
    end
  end

  assign load_ready   = (state_q == S_LOAD);
  assign imem_we      = (load_valid & load_ready) | fill_active;
  assign imem_waddr   = addr_q;
  assign imem_wdata   = fill_active ? 32'd0 : load_data;
  assign core_reset   = core_reset_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign halt_cause   = cause_q;
  assign halt_pc      = hpc_q;
  assign cycle_count  = cycle_q;
  assign words_loaded = words_q;

endmodule
